// File: rtl/breakout_game_ctrl_pkg.sv
// Breakout game controller shared types.
// State encodings and BCD limits.
package breakout_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_t;

  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam logic [15:0] SCORE_MAX = 16'h9999;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Game controller <-> graph/keyboard/display bundle.
// master = game controller, slave = surrounding screen logic.
interface breakout_game_ctrl_if;
  logic        tick;
  logic [4:0]  key_code;
  logic        hit;
  logic        miss;
  logic        bricks_clear;
  logic        gra_still;
  logic        ball_reset;
  logic [1:0]  state;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        win;

  modport master (
    input  tick, key_code, hit, miss, bricks_clear,
    output gra_still, ball_reset, state, score, lives, win
  );

  modport slave (
    output tick, key_code, hit, miss, bricks_clear,
    input  gra_still, ball_reset, state, score, lives, win
  );
endinterface

// File: rtl/breakout_game_ctrl_bcd_counter4.sv
// Four-digit BCD up counter, saturating at 9999.
// clr has priority over inc.
module bcd_counter4
  import breakout_game_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] bcd
);

  logic [15:0] nxt;
  logic        carry;

  // ripple +1 through the digits, 9 rolls to 0
  always_comb begin
    nxt   = bcd;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd[i*4 +: 4] == BCD_MAX) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = bcd[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  // score register; holds at 9999 instead of wrapping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcd <= '0;
    end else if (clr) begin
      bcd <= '0;
    end else if (inc && bcd != SCORE_MAX) begin
      bcd <= nxt;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: newgame/play/newball/over,
// lives, inter-ball delay and BCD score.
module breakout_game_ctrl
  import breakout_game_ctrl_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int DELAY_TICKS = 120,
  parameter int TMR_W       = 8
) (
  input logic                  clk,
  input logic                  rstn,
  breakout_game_ctrl_if.master gif
);

  localparam logic [TMR_W-1:0] T_LAST = TMR_W'(DELAY_TICKS - 1);
  localparam logic [TMR_W-1:0] T_DONE = TMR_W'(DELAY_TICKS);
  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);
  localparam logic [1:0]       L_INIT = 2'(LIVES_INIT);

  game_state_t      st_q;
  logic [TMR_W-1:0] tmr_q;
  logic [1:0]       lives_q;
  logic             win_q;
  logic             br_q;
  logic             hit_q, miss_q, key_q;
  logic             key_any;
  logic             hit_rise, miss_rise, key_rise;
  logic             sc_clr, sc_inc;
  logic [15:0]      score_w;

  assign key_any   = |gif.key_code;
  assign hit_rise  = gif.hit & ~hit_q;
  assign miss_rise = gif.miss & ~miss_q;
  assign key_rise  = key_any & ~key_q;

  assign sc_clr = (st_q == ST_NEWGAME) & key_rise;
  assign sc_inc = (st_q == ST_PLAY) & hit_rise;

  // one-flop history so held levels act only once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      key_q  <= 1'b0;
    end else begin
      hit_q  <= gif.hit;
      miss_q <= gif.miss;
      key_q  <= key_any;
    end
  end

  // game state machine with lives, win and delay timer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= ST_NEWGAME;
      tmr_q   <= '0;
      lives_q <= L_INIT;
      win_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      br_q <= 1'b0;
      unique case (st_q)
        ST_NEWGAME: begin
          if (key_rise) begin
            st_q    <= ST_PLAY;
            lives_q <= L_INIT;
            win_q   <= 1'b0;
            br_q    <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (gif.bricks_clear) begin
            st_q  <= ST_OVER;
            win_q <= 1'b1;
            tmr_q <= '0;
          end else if (miss_rise) begin
            tmr_q <= '0;
            if (lives_q > 2'd1) begin
              lives_q <= lives_q - 2'd1;
              st_q    <= ST_NEWBALL;
            end else begin
              lives_q <= 2'd0;
              win_q   <= 1'b0;
              st_q    <= ST_OVER;
            end
          end
        end
        ST_NEWBALL: begin
          if (gif.tick) begin
            tmr_q <= tmr_q + T_ONE;
            if (tmr_q == T_LAST) begin
              st_q <= ST_PLAY;
              br_q <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (key_rise && tmr_q == T_DONE) begin
            st_q <= ST_NEWGAME;
          end else if (gif.tick && tmr_q != T_DONE) begin
            tmr_q <= tmr_q + T_ONE;
          end
        end
      endcase
    end
  end

  bcd_counter4 u_score (
    .clk  (clk),
    .rstn (rstn),
    .clr  (sc_clr),
    .inc  (sc_inc),
    .bcd  (score_w)
  );

  assign gif.state      = st_q;
  assign gif.gra_still  = (st_q != ST_PLAY);
  assign gif.ball_reset = br_q;
  assign gif.score      = score_w;
  assign gif.lives      = lives_q;
  assign gif.win        = win_q;

endmodule
